// File: rtl/mem_y_banked.sv
// Banked Y memory: NUM_BANKS register-array banks on one shared address, a valid/ready
// request port, a 2-cycle read pipeline and a clear sequencer that zeroes the array.

module mem_y_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              rzero,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    // rzero covers a disabled bank and a sweep zeroing this address on the same edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)  rdata <= '0;
        else if (re)   rdata <= rzero ? '0 : mem[raddr];
    end
endmodule

module mem_y_banked #(
    parameter int DATA_W    = 32,
    parameter int NUM_BANKS = 2,
    parameter int ADDR_W    = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [NUM_BANKS*DATA_W-1:0]   req_wdata,
    input  logic [NUM_BANKS-1:0]          req_bank_en,
    output logic                          rd_valid,
    output logic [NUM_BANKS*DATA_W-1:0]   rd_data,
    input  logic                          init_start,
    output logic                          init_busy,
    output logic                          init_done
);
    localparam int STAGES = 2;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [NUM_BANKS-1:0] en;
    } rd_req_t;

    state_t                           state;
    logic [ADDR_W-1:0]                clr_cnt;
    logic                             clr_we;
    logic                             clr_hit;
    logic                             accept;
    logic                             wr_acc;
    logic                             rd_acc;
    logic [STAGES:0]                  vld_pipe;
    rd_req_t                          rd_req_q;
    logic [NUM_BANKS-1:0][DATA_W-1:0] bank_q;

    assign accept   = req_valid & req_ready;
    assign wr_acc   = accept & req_write;
    assign rd_acc   = accept & ~req_write;
    assign clr_we   = (state == ST_INIT);
    assign clr_hit  = clr_we && (clr_cnt == rd_req_q.addr);
    assign rd_valid = vld_pipe[STAGES];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_INIT;
            clr_cnt   <= '0;
            req_ready <= 1'b0;
            init_busy <= 1'b1;
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b0;
            case (state)
                ST_INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (&clr_cnt) begin
                        state     <= ST_RUN;
                        req_ready <= 1'b1;
                        init_busy <= 1'b0;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (init_start) begin
                        state     <= ST_INIT;
                        clr_cnt   <= '0;
                        req_ready <= 1'b0;
                        init_busy <= 1'b1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // accept edge -> rd_req_q, next edge -> bank_q, next edge -> rd_data
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            rd_req_q <= '0;
            rd_data  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], rd_acc};
            if (rd_acc) begin
                rd_req_q.addr <= req_addr;
                rd_req_q.en   <= req_bank_en;
            end
            if (vld_pipe[STAGES-1]) rd_data <= bank_q;
        end
    end

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        mem_y_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clock   (clock),
            .reset_n (reset_n),
            .we      (clr_we | (wr_acc & req_bank_en[k])),
            .waddr   (clr_we ? clr_cnt : req_addr),
            .wdata   (clr_we ? {DATA_W{1'b0}} : req_wdata[k*DATA_W +: DATA_W]),
            .re      (vld_pipe[0]),
            .raddr   (rd_req_q.addr),
            .rzero   (clr_hit | ~rd_req_q.en[k]),
            .rdata   (bank_q[k])
        );
    end
endmodule
